// File: rtl/mem_bus_slave.sv
// Word-addressed data-bus responder with programmable wait states.
// Active-low strobe/ready handshake; out-of-range accesses complete with bus_err.
module mem_bus_slave #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1,
  parameter bit INIT_ZERO   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        asn,
  input  logic [29:0] addr,
  input  logic        rw,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        rdy_n,
  output logic        bus_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic        rdy_n_q, rdy_n_d;
  logic        bus_err_q, bus_err_d;
  logic        rd_ok_q, rd_ok_d;
  logic [31:0] mem_rd_q;

  logic              accept;
  logic              ack_go;
  logic              in_range;
  logic              mem_we;
  logic [29:0]       req_addr;
  logic              req_rw;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] idx;

  // Zero fill only matters in simulation; synthesis ignores the initializer.
  logic [31:0] mem [DEPTH] =
    '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  // With no wait states the ACK-entry edge is the accept edge itself,
  // so the live request must be used while still in IDLE.
  assign req_addr  = (state_q == S_IDLE) ? addr  : addr_q;
  assign req_rw    = (state_q == S_IDLE) ? rw    : rw_q;
  assign req_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
  assign idx       = req_addr[ADDR_W-1:0];
  assign in_range  = ((req_addr >> ADDR_W) == '0);
  assign accept    = (state_q == S_IDLE) && !asn;
  assign mem_we    = ack_go && req_rw && in_range && !reset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_go    = 1'b0;
    rdy_n_d   = 1'b1;
    bus_err_d = 1'b0;
    rd_ok_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!asn) begin
          if (WAIT_CYCLES == 0) begin
            ack_go = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (asn) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          ack_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (ack_go) begin
      state_d   = S_ACK;
      cnt_d     = '0;
      rdy_n_d   = 1'b0;
      bus_err_d = !in_range;
      rd_ok_d   = !req_rw && in_range;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdy_n_q   <= 1'b1;
      bus_err_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdy_n_q   <= rdy_n_d;
      bus_err_q <= bus_err_d;
      rd_ok_q   <= rd_ok_d;
      if (accept) begin
        addr_q  <= addr;
        rw_q    <= rw;
        wdata_q <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= req_wdata;
    end
    mem_rd_q <= mem[idx];
  end

  assign rd_data = rd_ok_q ? mem_rd_q : '0;
  assign rdy_n   = rdy_n_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_slave.sv
// Scoreboard bench for mem_bus_slave: three instances with
// WAIT_CYCLES of 1, 0 and 3 share one clock and one expectation queue.
module tb_mem_bus_slave;

  typedef struct {
    int          d;
    logic [31:0] rd;
    logic        err;
    int          cyc;
    string       nm;
  } exp_t;

  logic        clk;
  logic        reset   [3];
  logic        asn     [3];
  logic        rw      [3];
  logic [29:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [31:0] rd_data [3];
  logic        rdy_n   [3];
  logic        bus_err [3];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;

  function automatic int wc(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WCG = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    mem_bus_slave #(
      .ADDR_W     (12),
      .WAIT_CYCLES(WCG),
      .INIT_ZERO  (1'b1)
    ) u_dut (
      .clk    (clk),
      .reset  (reset[g]),
      .asn    (asn[g]),
      .addr   (addr[g]),
      .rw     (rw[g]),
      .wdata  (wdata[g]),
      .rd_data(rd_data[g]),
      .rdy_n  (rdy_n[g]),
      .bus_err(bus_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy_n[d] === 1'b0) begin
        if (sb.size() == 0 || sb[0].d != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy dut%0d: rdy_n=0 at cycle %0d, required no ready",
                   d, cyc);
        end else begin
          mon_e = sb.pop_front();
          checks += 3;
          if (rd_data[d] !== mon_e.rd) begin
            errors++;
            $display("FAIL %s rd_data: got %h, required %h",
                     mon_e.nm, rd_data[d], mon_e.rd);
          end
          if (bus_err[d] !== mon_e.err) begin
            errors++;
            $display("FAIL %s bus_err: got %b, required %b",
                     mon_e.nm, bus_err[d], mon_e.err);
          end
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL %s latency: ready at cycle %0d, required %0d",
                     mon_e.nm, cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the ACK cycle.
  task automatic access(input int d, input logic w, input logic [29:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input string nm,
                        input bit rel, input bit mutate);
    bit seen;
    asn[d]   = 1'b0;
    rw[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    sb.push_back('{d: d, rd: exp_rd, err: exp_err,
                   cyc: cyc + 1 + wc(d), nm: nm});
    if (mutate) begin
      @(posedge clk);
      #1;
      addr[d]  = a + 30'd1;
      wdata[d] = ~wd;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy_n[d] === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: rdy_n stayed 1, required a ready pulse", nm);
    end
    @(posedge clk);
    #1;
    if (rel) asn[d] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset[d] = 1'b1;
      asn[d]   = 1'b1;
      rw[d]    = 1'b0;
      addr[d]  = '0;
      wdata[d] = '0;
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_rdy_n%0d", d), {31'd0, rdy_n[d]}, 32'd1);
      chk($sformatf("reset_rd_data%0d", d), rd_data[d], 32'd0);
      chk($sformatf("reset_bus_err%0d", d), {31'd0, bus_err[d]}, 32'd0);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    idle(2);

    // WAIT_CYCLES=1 write then read back
    access(0, 1, 30'h10, 32'hDEADBEEF, 32'h0, 0, "w1_write10", 1, 0);
    idle(1);
    access(0, 0, 30'h10, 32'h0, 32'hDEADBEEF, 0, "w1_read10", 1, 0);
    idle(1);

    // Out-of-range read/write must not touch aliased word 0
    access(0, 1, 30'h000, 32'h01020304, 32'h0, 0, "oor_pre_w0", 1, 0);
    access(0, 0, 30'h1000, 32'h0, 32'h0, 1, "oor_read", 1, 0);
    access(0, 1, 30'h1000, 32'hCAFEF00D, 32'h0, 1, "oor_write", 1, 0);
    access(0, 0, 30'h20000000, 32'h0, 32'h0, 1, "oor_read_top", 1, 0);
    access(0, 0, 30'h000, 32'h0, 32'h01020304, 0, "oor_read_w0", 1, 0);

    // Request fields changed after accept are ignored
    access(0, 1, 30'h40, 32'hA5A5A5A5, 32'h0, 0, "cap_write", 1, 1);
    access(0, 0, 30'h40, 32'h0, 32'hA5A5A5A5, 0, "cap_read40", 1, 0);
    access(0, 0, 30'h41, 32'h0, 32'h0, 0, "cap_read41", 1, 0);
    idle(1);

    // WAIT_CYCLES=0 back-to-back reads with asn held low
    access(1, 1, 30'h0, 32'h11111111, 32'h0, 0, "b2b_pre0", 1, 0);
    access(1, 1, 30'h1, 32'h22222222, 32'h0, 0, "b2b_pre1", 1, 0);
    access(1, 0, 30'h0, 32'h0, 32'h11111111, 0, "b2b_read0", 0, 0);
    access(1, 0, 30'h1, 32'h0, 32'h22222222, 0, "b2b_read1", 0, 0);
    access(1, 1, 30'h2, 32'h33333333, 32'h0, 0, "b2b_write2", 0, 0);
    access(1, 0, 30'h2, 32'h0, 32'h33333333, 0, "b2b_raw2", 1, 0);
    idle(1);

    // WAIT_CYCLES=3 abort after one wait cycle
    access(2, 1, 30'h20, 32'h0000BEEF, 32'h0, 0, "abort_pre", 1, 0);
    asn[2]   = 1'b0;
    rw[2]    = 1'b1;
    addr[2]  = 30'h20;
    wdata[2] = 32'h12345678;
    idle(2);
    asn[2] = 1'b1;
    idle(8);
    access(2, 0, 30'h20, 32'h0, 32'h0000BEEF, 0, "abort_read20", 1, 0);

    // Reset during WAIT of a write
    access(2, 1, 30'h30, 32'h0BADF00D, 32'h0, 0, "rstw_pre", 1, 0);
    asn[2]   = 1'b0;
    rw[2]    = 1'b1;
    addr[2]  = 30'h30;
    wdata[2] = 32'hFFFFFFFF;
    idle(2);
    reset[2] = 1'b1;
    #1;
    chk("rstw_rdy_n", {31'd0, rdy_n[2]}, 32'd1);
    chk("rstw_rd_data", rd_data[2], 32'd0);
    chk("rstw_bus_err", {31'd0, bus_err[2]}, 32'd0);
    asn[2] = 1'b1;
    idle(1);
    reset[2] = 1'b0;
    idle(1);
    access(2, 0, 30'h30, 32'h0, 32'h0BADF00D, 0, "rstw_read30", 1, 0);
    access(2, 1, 30'h30, 32'h55AA55AA, 32'h0, 0, "rstw_write30", 1, 0);
    access(2, 0, 30'h30, 32'h0, 32'h55AA55AA, 0, "rstw_reread30", 1, 0);

    // Reset during ACK of a read clears outputs at once
    asn[0]  = 1'b0;
    rw[0]   = 1'b0;
    addr[0] = 30'h10;
    idle(2);
    chk("rsta_pre_rdy_n", {31'd0, rdy_n[0]}, 32'd0);
    chk("rsta_pre_rd_data", rd_data[0], 32'hDEADBEEF);
    reset[0] = 1'b1;
    asn[0]   = 1'b1;
    #1;
    chk("rsta_rdy_n", {31'd0, rdy_n[0]}, 32'd1);
    chk("rsta_rd_data", rd_data[0], 32'd0);
    chk("rsta_bus_err", {31'd0, bus_err[0]}, 32'd0);
    idle(1);
    reset[0] = 1'b0;
    idle(1);
    access(0, 0, 30'h10, 32'h0, 32'hDEADBEEF, 0, "rsta_read10", 1, 0);

    idle(4);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_slave.md
Name: mem_bus_slave

Overview:
- Word-addressed memory responder on the CPU data bus.
- Answers the MEM-stage initiator's strobe, read/write and address signals with a registered read path and a programmable wait-state count.
- Returns an active-low ready pulse to the initiator.
- Serves as the on-chip scratchpad/data RAM target and as the reference slave for bus-level verification.

Parameters:
ADDR_W, 12, implemented word-address bits; array depth = 2**ADDR_W words of 32 bits
WAIT_CYCLES, 1, wait states inserted between accept and ready; legal range 0..15
INIT_ZERO, 0, 1 = simulation-only zero fill of the array at time 0; no effect on synthesis

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
asn  input  1  address strobe, active-low; held low by initiator until rdy_n sampled low
addr  input  30  word address; bits above ADDR_W-1 must be zero for an in-range access
rw  input  1  1 = write, 0 = read; stable while asn low
wdata  input  32  write data; stable while asn low
rd_data  output  32  read data, valid only in the cycle rdy_n is low
rdy_n  output  1  ready, active-low, one-cycle pulse completing the access
bus_err  output  1  high together with rdy_n low when the completed access was out of range

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-high. Reset forces state IDLE, rdy_n=1, rd_data=0, bus_err=0, wait counter=0. Array contents are not cleared by reset.
- States: IDLE, WAIT, ACK.
- IDLE:
  - If asn==0 at a rising edge: capture addr, rw, wdata into internal registers.
  - Go to WAIT with counter=WAIT_CYCLES-1, or straight to ACK if WAIT_CYCLES==0.
- WAIT:
  - Decrement counter each edge. At the edge where counter==0, go to ACK.
  - If asn==1 at any edge in WAIT: abort. Return to IDLE; no write, no ready, no error.
- Entry edge into ACK:
  - Write: in range -> array[addr] <= wdata. Out of range -> no write, bus_err <= 1.
  - Read: rd_data <= array[addr] if in range, else 0 with bus_err <= 1.
  - rdy_n <= 0.
- ACK (exactly one cycle): rdy_n=0. Next edge returns to IDLE with rdy_n=1, rd_data=0, bus_err=0.
- Latency: rdy_n low in the cycle following WAIT_CYCLES+1 rising edges after the edge where asn low is first sampled in IDLE.
  - WAIT_CYCLES=0: 1 cycle.
  - WAIT_CYCLES=1: 2 cycles.
- Back-to-back accesses:
  - asn still low in the IDLE cycle after ACK is a new access; the initiator deasserts asn or changes the request after seeing rdy_n low.
  - Minimum access spacing is WAIT_CYCLES+2 cycles.
- Range check: in range iff addr[29:ADDR_W]==0. Only addr[ADDR_W-1:0] indexes the array.
- Array: single-port, synchronous, one access per transaction. No read-modify-write; no byte enables (word accesses only, alignment handled by the initiator).
- Read-after-write to the same address in consecutive transactions returns the newly written data.
- Changes to addr, rw or wdata after the accept edge have no effect (captured values are used).
- Reset asserted mid-WAIT or mid-ACK:
  - Immediate return to IDLE outputs.
  - A write whose ACK-entry edge has not occurred is not performed.
  - A write already committed stays in the array.
- asn is ignored while in ACK.

Test Plan:
- WAIT_CYCLES=1: write addr=0x10, wdata=0xDEADBEEF (asn=0, rw=1), then read addr=0x10 -> rdy_n low exactly 2 cycles after accept on each access; read rd_data=0xDEADBEEF, bus_err=0.
- WAIT_CYCLES=0: back-to-back reads of addr 0x0 then 0x1 (preloaded 0x11111111 / 0x22222222), asn held low throughout -> rdy_n pulses every 2 cycles; rd_data 0x11111111 then 0x22222222.
- Out-of-range: ADDR_W=12, read addr=0x1000 -> rdy_n and bus_err low/high together for one cycle, rd_data=0. Then write 0xCAFEF00D to addr=0x1000 and read addr=0x000 -> word 0 unchanged.
- Abort: WAIT_CYCLES=3, write addr=0x20, wdata=0x12345678, asn raised after 1 wait cycle -> no rdy_n pulse. A subsequent read of 0x20 returns its prior value.
- Reset mid-operation: assert reset during WAIT of a write to 0x30 -> rdy_n=1, rd_data=0, bus_err=0 immediately. After release, read 0x30 returns its prior value and a write completes normally.
- Captured-request check: change addr/wdata during WAIT after accepting write addr=0x40, wdata=0xA5A5A5A5 -> array[0x40]=0xA5A5A5A5; new addr untouched.
